// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types, segment patterns and constant helpers for seq_bcd_display
package display_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      ENCODE
   } state_t;

   // Active-high patterns, bit order gfedcba
   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_BLANK = 7'h00;
   localparam logic [6:0] SEG_DASH  = 7'h40;

   function automatic longint unsigned pow10(input int n);
      longint unsigned p;
      p = 1;
      for (int i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

   // Never returns less than 1 so a counter always has at least one bit
   function automatic int clog2(input int n);
      int w;
      w = 1;
      for (int i = 1; i < 32; i++) if ((1 << i) < n) w = i + 1;
      return w;
   endfunction

endpackage

// File: rtl/digit_seg_enc.sv
// rtl/digit_seg_enc.sv - one BCD nibble to a seven-segment pattern with blank/dash/polarity control
module digit_seg_enc (
   input  logic [3:0] nibble,
   input  logic       blank,
   input  logic       dash,
   input  logic       active_low,
   output logic [6:0] seg
);
   import display_pkg::*;

   logic [6:0] pat;

   always_comb begin
      pat = SEG_BLANK;
      if (dash) begin
         pat = SEG_DASH;
      end else if (!blank) begin
         case (nibble)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_BLANK;
         endcase
      end
      seg = active_low ? ~pat : pat;
   end

endmodule

// File: rtl/seq_bcd_display.sv
// rtl/seq_bcd_display.sv - iterative double-dabble binary to seven-segment display driver
module seq_bcd_display #(
   parameter int IN_W           = 9,
   parameter int DIGITS         = 3,
   parameter int BLANK_LZ       = 1,
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  valid_in,
   input  logic [IN_W-1:0]       value,
   output logic                  ready,
   output logic [7*DIGITS-1:0]   seg,
   output logic                  seg_valid,
   output logic                  overflow
);
   import display_pkg::*;

   localparam int              CNT_W     = clog2(IN_W);
   localparam int              BCD_W     = 4 * DIGITS;
   localparam longint unsigned LIMIT     = pow10(DIGITS) - 1;
   localparam logic [6:0]      BLANK_PAT = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic [CNT_W-1:0] LAST     = CNT_W'(IN_W - 1);

   state_t              state, next_state;
   logic [IN_W-1:0]     shreg;
   logic [BCD_W-1:0]    bcd, bcd_adj;
   logic [CNT_W-1:0]    cnt;
   logic                ovf_q;
   logic                lz;
   logic [DIGITS-1:0]   blank;
   logic [7*DIGITS-1:0] seg_enc;

   assign ready = (state == IDLE);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      if (en) begin
         case (state)
            IDLE:    if (valid_in) next_state = SHIFT;
            SHIFT:   if (cnt == LAST) next_state = ENCODE;
            ENCODE:  next_state = IDLE;
            default: next_state = IDLE;
         endcase
      end
   end

   // Double-dabble correction applied before each shift
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
   end

   // A digit blanks only if it and every more significant digit are zero
   always_comb begin
      lz    = 1'b1;
      blank = '0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         lz       = lz & (bcd[4*k +: 4] == 4'd0);
         blank[k] = (BLANK_LZ != 0) && (k != 0) && lz;
      end
   end

   for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      digit_seg_enc u_enc (
         .nibble     (bcd[4*k +: 4]),
         .blank      (blank[k]),
         .dash       (ovf_q),
         .active_low (SEG_ACTIVE_LOW != 0),
         .seg        (seg_enc[7*k +: 7])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shreg     <= '0;
         bcd       <= '0;
         cnt       <= '0;
         ovf_q     <= 1'b0;
         seg       <= {DIGITS{BLANK_PAT}};
         seg_valid <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         seg_valid <= 1'b0;
         if (en) begin
            case (state)
               IDLE: begin
                  if (valid_in) begin
                     shreg <= value;
                     bcd   <= '0;
                     cnt   <= '0;
                     ovf_q <= (64'(value) > LIMIT);
                  end
               end
               SHIFT: begin
                  {bcd, shreg} <= {bcd_adj, shreg} << 1;
                  cnt          <= cnt + 1'b1;
               end
               ENCODE: begin
                  seg       <= seg_enc;
                  overflow  <= ovf_q;
                  seg_valid <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_seq_bcd_display.sv
// tb/tb_seq_bcd_display.sv - scoreboard bench for seq_bcd_display (3-digit and 2-digit instances)
module tb_seq_bcd_display;

   logic        clk;
   logic        rst;
   logic        en;
   logic        valid_in;
   logic [8:0]  value;
   logic        ready_a, seg_valid_a, overflow_a;
   logic [20:0] seg_a;
   logic        ready_b, seg_valid_b, overflow_b;
   logic [13:0] seg_b;

   seq_bcd_display #(.IN_W(9), .DIGITS(3), .BLANK_LZ(1), .SEG_ACTIVE_LOW(1)) u_dut_a (
      .clk(clk), .rst(rst), .en(en), .valid_in(valid_in), .value(value),
      .ready(ready_a), .seg(seg_a), .seg_valid(seg_valid_a), .overflow(overflow_a)
   );

   seq_bcd_display #(.IN_W(9), .DIGITS(2), .BLANK_LZ(1), .SEG_ACTIVE_LOW(1)) u_dut_b (
      .clk(clk), .rst(rst), .en(en), .valid_in(valid_in), .value(value),
      .ready(ready_b), .seg(seg_b), .seg_valid(seg_valid_b), .overflow(overflow_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   typedef struct {
      logic [20:0] seg;
      logic        ovf;
      int          acc;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   exp_t ea, eb;

   int n_checks = 0;
   int n_errors = 0;
   int n_acc = 0;
   int n_pulse_a = 0;
   int n_pulse_b = 0;
   int en_edges = 0;
   int phase = 0;
   logic throttle = 1'b0;
   logic prev_sv_a = 1'b0;
   logic prev_sv_b = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [20:0] model_seg(input int v, input int nd);
      logic [6:0]  tbl [10];
      logic [6:0]  pat;
      logic [20:0] r;
      int p, lim;
      tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
      r   = '1;
      lim = 1;
      for (int i = 0; i < nd; i++) lim = lim * 10;
      lim = lim - 1;
      p = 1;
      for (int k = 0; k < nd; k++) begin
         if (v > lim)             pat = 7'h40;
         else if (k > 0 && v < p) pat = 7'h00;
         else                     pat = tbl[(v / p) % 10];
         r[7*k +: 7] = ~pat;
         p = p * 10;
      end
      return r;
   endfunction

   function automatic logic model_ovf(input int v, input int nd);
      int lim;
      lim = 1;
      for (int i = 0; i < nd; i++) lim = lim * 10;
      return v > lim - 1;
   endfunction

   // Monitor: compare on seg_valid, then log acceptances for the next edge
   always @(negedge clk) begin
      if (rst) begin
         q_a.delete();
         q_b.delete();
         prev_sv_a = 1'b0;
         prev_sv_b = 1'b0;
      end else begin
         if (seg_valid_a) begin
            n_pulse_a++;
            check("sv_a_width", {31'd0, prev_sv_a}, 32'd0);
            check("ready_a_at_sv", {31'd0, ready_a}, 32'd1);
            if (q_a.size() == 0) begin
               check("sv_a_unexpected", 32'd1, 32'd0);
            end else begin
               ea = q_a.pop_front();
               check("seg_a", {11'd0, seg_a}, {11'd0, ea.seg});
               check("ovf_a", {31'd0, overflow_a}, {31'd0, ea.ovf});
               check("latency_a", en_edges - ea.acc, 32'd10);
            end
         end
         if (seg_valid_b) begin
            n_pulse_b++;
            check("sv_b_width", {31'd0, prev_sv_b}, 32'd0);
            if (q_b.size() == 0) begin
               check("sv_b_unexpected", 32'd1, 32'd0);
            end else begin
               eb = q_b.pop_front();
               check("seg_b", {18'd0, seg_b}, {18'd0, eb.seg[13:0]});
               check("ovf_b", {31'd0, overflow_b}, {31'd0, eb.ovf});
               check("latency_b", en_edges - eb.acc, 32'd10);
            end
         end
         prev_sv_a = seg_valid_a;
         prev_sv_b = seg_valid_b;
         if (en) en_edges++;
         if (valid_in && en && ready_a) begin
            n_acc++;
            q_a.push_back('{seg: model_seg(int'(value), 3), ovf: model_ovf(int'(value), 3), acc: en_edges});
         end
         if (valid_in && en && ready_b) begin
            q_b.push_back('{seg: model_seg(int'(value), 2), ovf: model_ovf(int'(value), 2), acc: en_edges});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      phase++;
      en = throttle ? (phase % 3 == 0) : 1'b1;
   endtask

   task automatic send(input int v);
      int start;
      start    = n_acc;
      value    = 9'(v);
      valid_in = 1'b1;
      for (int i = 0; i < 200 && n_acc == start; i++) step();
      valid_in = 1'b0;
      check("accept_timeout", {31'd0, n_acc != start}, 32'd1);
   endtask

   task automatic wait_done(input int target);
      for (int i = 0; i < 300 && n_pulse_a < target; i++) step();
      check("done_timeout", {31'd0, n_pulse_a >= target}, 32'd1);
   endtask

   int base_p, base_acc;

   initial begin
      rst      = 1'b1;
      en       = 1'b1;
      valid_in = 1'b0;
      value    = '0;
      step();
      step();
      rst = 1'b0;
      step();
      @(negedge clk);
      check("rst_seg_a", {11'd0, seg_a}, 32'h1FFFFF);
      check("rst_seg_b", {18'd0, seg_b}, 32'h3FFF);
      check("rst_ready", {31'd0, ready_a}, 32'd1);
      check("rst_sv", {31'd0, seg_valid_a}, 32'd0);
      check("rst_ovf", {31'd0, overflow_a}, 32'd0);

      send(359);
      wait_done(1);
      check("lit_359", {11'd0, seg_a}, {11'd0, 7'b0110000, 7'b0010010, 7'b0010000});

      // 0 is requested while 7 is in flight, so it lands in the seg_valid cycle
      send(7);
      send(0);
      wait_done(3);
      check("lit_0", {11'd0, seg_a}, {11'd0, 7'b1111111, 7'b1111111, 7'b1000000});

      send(100);
      wait_done(4);
      check("lit_100_b", {18'd0, seg_b}, {18'd0, 7'b0111111, 7'b0111111});
      check("lit_100_ovf_b", {31'd0, overflow_b}, 32'd1);
      send(99);
      send(511);
      wait_done(6);

      throttle = 1'b1;
      base_p   = n_pulse_a;
      base_acc = n_acc;
      value    = 9'd256;
      valid_in = 1'b1;
      repeat (20) step();
      valid_in = 1'b0;
      wait_done(base_p + 1);
      repeat (30) step();
      check("throttle_accepts", n_acc - base_acc, 32'd1);
      check("throttle_pulses", n_pulse_a - base_p, 32'd1);
      throttle = 1'b0;
      step();

      send(123);
      repeat (4) step();
      @(negedge clk);
      check("busy_ready", {31'd0, ready_a}, 32'd0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      check("abort_seg_a", {11'd0, seg_a}, 32'h1FFFFF);
      check("abort_ready", {31'd0, ready_a}, 32'd1);
      check("abort_sv", {31'd0, seg_valid_a}, 32'd0);
      base_p = n_pulse_a;
      repeat (20) step();
      check("abort_no_sv", n_pulse_a, base_p);

      send(45);
      wait_done(base_p + 1);
      check("lit_45", {11'd0, seg_a}, {11'd0, 7'b1111111, 7'b0011001, 7'b0010010});
      repeat (3) step();
      check("pulses_b_match", n_pulse_b, n_pulse_a);
      check("queue_a_empty", q_a.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/seq_bcd_display.md
# seq_bcd_display

Parametrised, sequential binary-to-seven-segment display driver, the next-generation replacement for the combinational BCD + segment-decode + output-register chain behind the angle processor. It accepts one unsigned binary value per request over a valid/ready handshake. It converts the value with an iterative double-dabble (one shift per enabled cycle), encodes each decimal digit to seven segments with optional leading-zero blanking and overflow dashes, and holds the result on registered outputs. It sits between the processing unit's result and the board's seven-segment pins.

## Interface
- IN_W, 9: width of the binary input value.
- DIGITS, 3: number of decimal digits driven.
- BLANK_LZ, 1: 1 = blank leading zero digits; 0 = show all digits.
- SEG_ACTIVE_LOW, 1: 1 = segment lit when bit is 0.

- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  clock enable; the FSM and datapath advance only when en=1.
- valid_in  in  1  request; accepted when valid_in & ready & en.
- value  in  IN_W  unsigned binary value, sampled at acceptance.
- ready  out  1  1 only in IDLE.
- seg  out  7*DIGITS  registered segments; seg[7k+6:7k] = digit k (k=0 ones), bit order gfedcba.
- seg_valid  out  1  one-clk pulse when seg/overflow update.
- overflow  out  1  registered; 1 if the last value exceeds 10^DIGITS-1.

## Operation
- FSM states: IDLE, SHIFT, ENCODE. All transitions require en=1; when en=0, all state is frozen.
- IDLE → SHIFT on acceptance:
  - load value into shift register; clear BCD register (4*DIGITS bits); cnt=0.
  - latch ovf_q = (value > 10^DIGITS-1).
- SHIFT, each enabled cycle:
  - add 3 to every BCD nibble ≥5, then shift {bcd, shreg} left one bit; cnt++.
  - after IN_W shifts (cnt==IN_W-1 on that edge) → ENCODE.
- ENCODE, one enabled cycle:
  - map each nibble to its segment pattern and register seg; overflow ← ovf_q; seg_valid ← 1; → IDLE.
- Blanking (BLANK_LZ=1): digit k is blank if all digits ≥k are zero and k>0. Value 0 shows "0" in digit 0.
- Overflow: every digit shows a dash (segment g only); blanking is not applied. BCD truncation beyond DIGITS is irrelevant in this case.
- Polarity: patterns are defined active-high and inverted when SEG_ACTIVE_LOW=1. Blank is all segments off.
- valid_in while ready=0 is ignored and never queued.
- seg and overflow hold their value until the next ENCODE.

## Timing
- Reset values: state IDLE, ready=1, seg = all blank (all ones when active-low), seg_valid=0, overflow=0, cnt=0.
- rst has priority over every other input, including a simultaneous valid_in. rst mid-conversion aborts the conversion: no seg_valid, seg is blanked.
- With en=1 continuously: request accepted at edge k; SHIFT on edges k+1..k+IN_W; ENCODE on edge k+IN_W+1. seg_valid is high and ready=1 for the clk cycle after that edge. Latency is IN_W+1 enabled edges after acceptance (10 for IN_W=9).
- seg_valid lasts exactly one clk regardless of en. It deasserts on the next edge.
- Back-to-back: a new request may be accepted in the same cycle seg_valid is high.

## Structure
- Package display_pkg holds:
  - state enum.
  - active-high segment constants SEG_0..SEG_9, SEG_BLANK, SEG_DASH.
  - function pow10(DIGITS) for the overflow limit.
  - function clog2 for the width of cnt.
- Sub-module digit_seg_enc (combinational): nibble, blank, dash, active_low → 7-bit pattern. Instantiate DIGITS times via generate.

## Test plan
- Reset with rst=1 for 2 cycles, then idle → seg=21'h1FFFFF, ready=1, seg_valid=0, overflow=0.
- value=359, en=1, valid_in one cycle → seg_valid 10 edges after acceptance. Digits 0..2 = 7'b0010000, 7'b0010010, 7'b0110000. overflow=0; ready=1 in the same cycle.
- value=7, then value=0 (BLANK_LZ=1) → digits 2,1 = 7'b1111111, digit0 = 7'b1111000; then digit0 = 7'b1000000, upper digits blank.
- Instance DIGITS=2, IN_W=9:
  - value=100 → overflow=1, both digits 7'b0111111.
  - value=99 → overflow=0, both digits 7'b0010000.
- en high 1 of every 3 clks, value=256; valid_in held high during busy → one conversion only. Result digits 6,5,2 appear after 10 enabled edges; seg_valid pulses once, one clk wide.
- rst pulsed on the 5th SHIFT cycle of value=123 → no seg_valid, seg blank, ready=1 next cycle. A following request of 45 → digits 5,4, digit2 blank.
